// File: rtl/mul_pipe_unit.sv
// Fully pipelined MUL/MNEG/SMULH/UMULH unit with valid/ready handshake, flush,
// and per-stage destination tags exported to the hazard detection unit.
module mul_pipe_unit #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          op_a,
  input  logic [WIDTH-1:0]          op_b,
  input  logic [1:0]                mode,
  input  logic [TAG_W-1:0]          tag_in,
  input  logic                      regwrite_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          result,
  output logic [TAG_W-1:0]          tag_out,
  output logic                      regwrite_out,
  output logic [STAGES-1:0]         pending_valid,
  output logic [STAGES*TAG_W-1:0]   pending_tags,
  output logic                      busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [TAG_W-1:0] TAG_XZR = TAG_W'(31);
  localparam logic [1:0] MODE_MUL   = 2'b00;
  localparam logic [1:0] MODE_SMULH = 2'b01;
  localparam logic [1:0] MODE_UMULH = 2'b10;
  localparam logic [1:0] MODE_MNEG  = 2'b11;

  // Only SMULH sign-extends; the low half is identical for every signedness.
  function automatic logic [PW-1:0] form_product(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       md);
    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;
    if (md == MODE_SMULH) begin
      a_x = {{WIDTH{a[WIDTH-1]}}, a};
      b_x = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      a_x = {{WIDTH{1'b0}}, a};
      b_x = {{WIDTH{1'b0}}, b};
    end
    return a_x * b_x;
  endfunction

  function automatic logic [WIDTH-1:0] select_result(input logic [PW-1:0] p,
                                                     input logic [1:0]    md);
    logic [WIDTH-1:0] r;
    case (md)
      MODE_MUL:   r = p[WIDTH-1:0];
      MODE_SMULH: r = p[PW-1:WIDTH];
      MODE_UMULH: r = p[PW-1:WIDTH];
      MODE_MNEG:  r = {WIDTH{1'b0}} - p[WIDTH-1:0];
      default:    r = p[WIDTH-1:0];
    endcase
    return r;
  endfunction

  logic [STAGES-1:0]             vld_q,  vld_d;
  logic [STAGES-1:0]             rw_q,   rw_d;
  logic [STAGES-1:0]             pend_q, pend_d;
  logic [STAGES-1:0][TAG_W-1:0]  tag_q,  tag_d;
  logic [STAGES-1:0][1:0]        mode_q, mode_d;
  logic [STAGES-1:0][PW-1:0]     prod_q, prod_d;
  logic                          adv_s;

  assign out_valid = vld_q[STAGES-1];
  assign adv_s     = !(out_valid && !out_ready);

  // Stage shift on advance; flush kills every valid bit regardless of stall.
  always_comb begin
    vld_d  = vld_q;
    rw_d   = rw_q;
    pend_d = pend_q;
    tag_d  = tag_q;
    mode_d = mode_q;
    prod_d = prod_q;
    if (adv_s) begin
      vld_d[0]  = in_valid;
      rw_d[0]   = regwrite_in;
      pend_d[0] = in_valid && regwrite_in && (tag_in != TAG_XZR);
      tag_d[0]  = tag_in;
      mode_d[0] = mode;
      prod_d[0] = form_product(op_a, op_b, mode);
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        rw_d[i]   = rw_q[i-1];
        pend_d[i] = pend_q[i-1];
        tag_d[i]  = tag_q[i-1];
        mode_d[i] = mode_q[i-1];
        prod_d[i] = prod_q[i-1];
      end
    end else begin
      vld_d = vld_q;
    end
    if (flush) begin
      vld_d  = {STAGES{1'b0}};
      pend_d = {STAGES{1'b0}};
    end else begin
      pend_d = pend_d;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      rw_q   <= '0;
      pend_q <= '0;
      tag_q  <= '0;
      mode_q <= '0;
      prod_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rw_q   <= rw_d;
      pend_q <= pend_d;
      tag_q  <= tag_d;
      mode_q <= mode_d;
      prod_q <= prod_d;
    end
  end

  // Last-stage registers hold still under stall, so the result stays stable.
  assign result        = select_result(prod_q[STAGES-1], mode_q[STAGES-1]);
  assign tag_out       = tag_q[STAGES-1];
  assign regwrite_out  = rw_q[STAGES-1];
  assign pending_valid = pend_q;
  assign pending_tags  = tag_q;
  assign busy          = |vld_q;
  assign in_ready      = adv_s;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit: a STAGES=3 instance and a STAGES=1 instance.
module tb_mul_pipe_unit;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  logic        a_in_valid, a_in_ready, a_regwrite_in, a_flush, a_out_valid, a_out_ready;
  logic        a_regwrite_out, a_busy;
  logic [63:0] a_op_a, a_op_b, a_result;
  logic [1:0]  a_mode;
  logic [4:0]  a_tag_in, a_tag_out;
  logic [2:0]  a_pending_valid;
  logic [14:0] a_pending_tags;

  logic        b_in_valid, b_in_ready, b_regwrite_in, b_flush, b_out_valid, b_out_ready;
  logic        b_regwrite_out, b_busy;
  logic [63:0] b_op_a, b_op_b, b_result;
  logic [1:0]  b_mode;
  logic [4:0]  b_tag_in, b_tag_out;
  logic [0:0]  b_pending_valid;
  logic [4:0]  b_pending_tags;

  mul_pipe_unit #(.WIDTH(64), .STAGES(3), .TAG_W(5)) u3 (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op_a(a_op_a), .op_b(a_op_b), .mode(a_mode), .tag_in(a_tag_in),
    .regwrite_in(a_regwrite_in), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .result(a_result), .tag_out(a_tag_out),
    .regwrite_out(a_regwrite_out), .pending_valid(a_pending_valid),
    .pending_tags(a_pending_tags), .busy(a_busy)
  );

  mul_pipe_unit #(.WIDTH(64), .STAGES(1), .TAG_W(5)) u1 (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op_a(b_op_a), .op_b(b_op_b), .mode(b_mode), .tag_in(b_tag_in),
    .regwrite_in(b_regwrite_in), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .result(b_result), .tag_out(b_tag_out),
    .regwrite_out(b_regwrite_out), .pending_valid(b_pending_valid),
    .pending_tags(b_pending_tags), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [63:0] x, input logic [63:0] y,
                         input logic [1:0] m, input logic [4:0] t, input logic rw);
    a_in_valid = v; a_op_a = x; a_op_b = y; a_mode = m; a_tag_in = t; a_regwrite_in = rw;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_a(1'b0, 64'd0, 64'd0, 2'b00, 5'd0, 1'b0);
    a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_op_a = 64'd0; b_op_b = 64'd0; b_mode = 2'b00;
    b_tag_in = 5'd0; b_regwrite_in = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    total++; if (a_pending_valid !== 3'b000) begin bad++; $display("FAIL reset_pending got=%b exp=000", a_pending_valid); end
    total++; if (a_result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", a_result); end
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_s1_out_valid got=%b exp=0", b_out_valid); end
  endtask

  task automatic test_modes();
    logic [63:0] xa [4] = '{64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] xb [4] = '{64'd6, 64'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    logic [1:0]  md [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [63:0] ex [4] = '{64'd42, 64'hFFFF_FFFF_FFFF_FFD6, 64'd0, 64'd1};
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive_a(1'b1, xa[k], xb[k], md[k], 5'(k + 1), 1'b1);
      else       drive_a(1'b0, 64'd0, 64'd0, 2'b00, 5'd0, 1'b0);
      tick();
      if (k < 2) begin
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL mode_early k=%0d got=%b exp=0", k, a_out_valid); end
      end else if (k >= 2 && k < 6) begin
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL mode_valid k=%0d got=%b exp=1", k, a_out_valid); end
        total++; if (a_result !== ex[k-2]) begin bad++; $display("FAIL mode_result k=%0d got=%h exp=%h", k, a_result, ex[k-2]); end
        total++; if (a_tag_out !== 5'(k - 1)) begin bad++; $display("FAIL mode_tag k=%0d got=%0d exp=%0d", k, a_tag_out, k - 1); end
      end else begin
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL mode_drain got=%b exp=0", a_out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    drive_a(1'b1, 64'd3, 64'd4, 2'b00, 5'd5, 1'b1); tick();
    drive_a(1'b1, 64'd10, 64'd10, 2'b00, 5'd6, 1'b1); tick();
    drive_a(1'b1, 64'h100, 64'h100, 2'b00, 5'd7, 1'b1); tick();
    drive_a(1'b0, 64'd0, 64'd0, 2'b00, 5'd0, 1'b0);
    a_out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, a_in_ready); end
      total++; if (a_result !== 64'd12 || a_tag_out !== 5'd5 || a_out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold k=%0d got=%h/%0d/%b exp=c/5/1", k, a_result, a_tag_out, a_out_valid);
      end
      if (k < 4) tick();
    end
    a_out_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", a_in_ready); end
    tick();
    total++; if (a_out_valid !== 1'b1 || a_result !== 64'd100 || a_tag_out !== 5'd6) begin
      bad++; $display("FAIL bp_second got=%b/%h/%0d exp=1/64/6", a_out_valid, a_result, a_tag_out);
    end
    tick();
    total++; if (a_out_valid !== 1'b1 || a_result !== 64'h10000 || a_tag_out !== 5'd7) begin
      bad++; $display("FAIL bp_third got=%b/%h/%0d exp=1/10000/7", a_out_valid, a_result, a_tag_out);
    end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    drive_a(1'b1, 64'd2, 64'd2, 2'b00, 5'd8, 1'b1); tick();
    drive_a(1'b1, 64'd3, 64'd3, 2'b00, 5'd9, 1'b1); tick();
    total++; if (a_pending_valid !== 3'b011) begin bad++; $display("FAIL flush_pre_pending got=%b exp=011", a_pending_valid); end
    drive_a(1'b1, 64'd4, 64'd4, 2'b00, 5'd10, 1'b1);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    drive_a(1'b0, 64'd0, 64'd0, 2'b00, 5'd0, 1'b0);
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", a_busy); end
    total++; if (a_pending_valid !== 3'b000) begin bad++; $display("FAIL flush_pending got=%b exp=000", a_pending_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_out k=%0d got=%b exp=0", k, a_out_valid); end
    end
  endtask

  task automatic test_pending_tags();
    drive_a(1'b1, 64'd1, 64'd1, 2'b00, 5'd3, 1'b1); tick();
    total++; if (a_pending_valid !== 3'b001 || a_pending_tags[4:0] !== 5'd3) begin
      bad++; $display("FAIL pend_s0 got=%b/%0d exp=001/3", a_pending_valid, a_pending_tags[4:0]);
    end
    drive_a(1'b1, 64'd2, 64'd1, 2'b00, 5'd31, 1'b1); tick();
    total++; if (a_pending_valid !== 3'b010 || a_pending_tags[9:5] !== 5'd3) begin
      bad++; $display("FAIL pend_s1 got=%b/%0d exp=010/3", a_pending_valid, a_pending_tags[9:5]);
    end
    drive_a(1'b1, 64'd3, 64'd1, 2'b00, 5'd4, 1'b0); tick();
    drive_a(1'b0, 64'd0, 64'd0, 2'b00, 5'd0, 1'b0);
    total++; if (a_pending_valid !== 3'b100 || a_pending_tags[14:10] !== 5'd3) begin
      bad++; $display("FAIL pend_s2 got=%b/%0d exp=100/3", a_pending_valid, a_pending_tags[14:10]);
    end
    total++; if (a_out_valid !== 1'b1 || a_tag_out !== 5'd3 || a_regwrite_out !== 1'b1 || a_result !== 64'd1) begin
      bad++; $display("FAIL pend_out3 got=%b/%0d/%b/%h exp=1/3/1/1", a_out_valid, a_tag_out, a_regwrite_out, a_result);
    end
    tick();
    total++; if (a_pending_valid !== 3'b000) begin bad++; $display("FAIL pend_xzr got=%b exp=000", a_pending_valid); end
    total++; if (a_out_valid !== 1'b1 || a_tag_out !== 5'd31 || a_regwrite_out !== 1'b1 || a_result !== 64'd2) begin
      bad++; $display("FAIL pend_out31 got=%b/%0d/%b/%h exp=1/31/1/2", a_out_valid, a_tag_out, a_regwrite_out, a_result);
    end
    tick();
    total++; if (a_out_valid !== 1'b1 || a_tag_out !== 5'd4 || a_regwrite_out !== 1'b0 || a_result !== 64'd3) begin
      bad++; $display("FAIL pend_out4 got=%b/%0d/%b/%h exp=1/4/0/3", a_out_valid, a_tag_out, a_regwrite_out, a_result);
    end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL pend_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_reset_midflight();
    drive_a(1'b1, 64'd5, 64'd5, 2'b00, 5'd11, 1'b1); tick();
    drive_a(1'b1, 64'd6, 64'd6, 2'b00, 5'd12, 1'b1); tick();
    drive_a(1'b1, 64'd7, 64'd7, 2'b00, 5'd13, 1'b1); tick();
    drive_a(1'b0, 64'd0, 64'd0, 2'b00, 5'd0, 1'b0);
    total++; if (a_busy !== 1'b1 || a_result !== 64'd25) begin
      bad++; $display("FAIL rstmid_pre got=%b/%h exp=1/19", a_busy, a_result);
    end
    #2;
    reset = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_result !== 64'd0 || a_tag_out !== 5'd0) begin
      bad++; $display("FAIL rstmid_clear got=%b/%b/%h/%0d exp=0/0/0/0", a_out_valid, a_busy, a_result, a_tag_out);
    end
    total++; if (a_pending_valid !== 3'b000 || a_pending_tags !== 15'd0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_pending got=%b/%h/%b exp=000/0/1", a_pending_valid, a_pending_tags, a_in_ready);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after k=%0d got=%b exp=0", k, a_out_valid); end
    end
  endtask

  task automatic test_single_stage();
    b_in_valid = 1'b1; b_op_a = 64'd3; b_op_b = 64'd5; b_mode = 2'b00; b_tag_in = 5'd2; b_regwrite_in = 1'b1;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_out_valid !== 1'b1 || b_result !== 64'd15 || b_tag_out !== 5'd2) begin
      bad++; $display("FAIL s1_result got=%b/%h/%0d exp=1/f/2", b_out_valid, b_result, b_tag_out);
    end
    total++; if (b_pending_valid !== 1'b1) begin bad++; $display("FAIL s1_pending got=%b exp=1", b_pending_valid); end
    tick();
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL s1_drain got=%b exp=0", b_out_valid); end
    b_in_valid = 1'b1; b_op_a = 64'd9; b_op_b = 64'd1; b_mode = 2'b11; b_tag_in = 5'd3;
    b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_in_ready !== 1'b0 || b_result !== 64'hFFFF_FFFF_FFFF_FFF7) begin
      bad++; $display("FAIL s1_stall got=%b/%h exp=0/fffffffffffffff7", b_in_ready, b_result);
    end
    tick();
    total++; if (b_out_valid !== 1'b1 || b_result !== 64'hFFFF_FFFF_FFFF_FFF7) begin
      bad++; $display("FAIL s1_hold got=%b/%h exp=1/fffffffffffffff7", b_out_valid, b_result);
    end
    b_out_ready = 1'b1;
    tick();
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL s1_release got=%b exp=0", b_out_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_modes();
    test_backpressure();
    test_flush();
    test_pending_tags();
    test_reset_midflight();
    test_single_stage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
